// File: rtl/uart_rx_sample_gen.sv
// UART receive bit-clock generator: start-edge detect, mid-bit sample strobes for one frame.
// Optional RECV_MAJORITY_EN: 2-of-3 vote over the last three rx_s samples at each evaluation.
module uart_rx_sample_gen #(
    parameter int CLK_DIV     = 5208,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       en,
    output logic       sample,
    output logic       bit_val,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err,
    output logic       start_err
);
    localparam int HALF = CLK_DIV / 2;
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST    = 4'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q;
    logic [15:0]            cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_d_q, rx_eval;
    logic                   sample_q, bit_val_q, busy_q, done_q, ferr_q, serr_q;
    logic [3:0]             bit_idx_q;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Line idles high, so the synchroniser resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            rx_d_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_d_q <= rx_s;
        end
    end

`ifdef RECV_MAJORITY_EN
    logic rx_dd_q;

    always_ff @(posedge clk) begin
        if (rst) rx_dd_q <= 1'b1;
        else     rx_dd_q <= rx_d_q;
    end

    assign rx_eval = (rx_s & rx_d_q) | (rx_s & rx_dd_q) | (rx_d_q & rx_dd_q);
`else
    assign rx_eval = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sample_q  <= 1'b0;
            bit_val_q <= 1'b0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            serr_q   <= 1'b0;
            if (!en) begin
                // Abort silently; bit_idx keeps its last value.
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (rx_d_q && !rx_s) begin
                            state_q <= START;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q <= '0;
                            if (!rx_eval) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                serr_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    DATA: begin
                        if (cnt_q == DIV_M1) begin
                            cnt_q     <= '0;
                            sample_q  <= 1'b1;
                            bit_val_q <= rx_eval;
                            bit_idx_q <= bit_cnt_q;
                            if (bit_cnt_q == LAST) state_q <= STOP;
                            else                   bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    STOP: begin
                        if (cnt_q == DIV_M1) begin
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                            ferr_q  <= !rx_eval;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sample     = sample_q;
    assign bit_val    = bit_val_q;
    assign bit_idx    = bit_idx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;
    assign start_err  = serr_q;
endmodule

// File: tb/tb_uart_rx_sample_gen.sv
// Directed bench for uart_rx_sample_gen with CLK_DIV=16, DATA_BITS=8, SYNC_STAGES=2.
// Step m drives rx after edge p+m and samples at the following negedge; cycle E is step 2.
module tb_uart_rx_sample_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       en  = 1'b1;
    logic       sample, bit_val, busy, frame_done, frame_err, start_err;
    logic [3:0] bit_idx;

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_sample_gen #(.CLK_DIV(16), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .en(en),
        .sample(sample), .bit_val(bit_val), .bit_idx(bit_idx), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err), .start_err(start_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int m, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rs, input logic e);
        @(posedge clk);
        #1;
        rx  = r;
        rst = rs;
        en  = e;
        @(negedge clk);
    endtask

    function automatic logic line_bit(input int m, input logic [7:0] d, input logic stop);
        int j;
        j = m / 16;
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return stop;
    endfunction

    // Full 160-cycle frame. Sample k visible at step 27+16k, frame_done at 155.
    task automatic frame(input logic [7:0] d, input logic stop, input int glitch_m,
                         input logic [7:0] exp_d);
        for (int m = 0; m < 160; m++) begin
            logic r;
            int   k;
            logic es;
            r = line_bit(m, d, stop);
            if (m == glitch_m) r = 1'b1;
            step(r, 1'b0, 1'b1);
            k  = (m - 27) / 16;
            es = (m >= 27) && ((m - 27) % 16 == 0) && (k < 8);
            chk("sample", m, {3'b0, sample}, {3'b0, es});
            if (es) begin
                chk("bit_val", m, {3'b0, bit_val}, {3'b0, exp_d[k]});
                chk("bit_idx", m, bit_idx, 4'(k));
            end
            chk("frame_done", m, {3'b0, frame_done}, {3'b0, m == 155});
            chk("frame_err", m, {3'b0, frame_err}, {3'b0, (m == 155) && !stop});
            chk("start_err", m, {3'b0, start_err}, 4'd0);
            chk("busy", m, {3'b0, busy}, {3'b0, (m >= 3) && (m < 155)});
        end
    endtask

    task automatic idle(input int n);
        for (int m = 0; m < n; m++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("idle_busy", m, {3'b0, busy}, 4'd0);
        end
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        chk("rst_sample", 0, {3'b0, sample}, 4'd0);
        chk("rst_busy", 0, {3'b0, busy}, 4'd0);
        chk("rst_bit_idx", 0, bit_idx, 4'd0);
        chk("rst_done", 0, {3'b0, frame_done}, 4'd0);
        chk("rst_serr", 0, {3'b0, start_err}, 4'd0);
        idle(6);

        // 0x55, good stop
        frame(8'h55, 1'b1, -1, 8'h55);
        idle(5);

        // Short low pulse: start_err at step 11, busy 3..10
        for (int m = 0; m < 40; m++) begin
            step((m < 3) ? 1'b0 : 1'b1, 1'b0, 1'b1);
            chk("serr_pulse", m, {3'b0, start_err}, {3'b0, m == 11});
            chk("serr_busy", m, {3'b0, busy}, {3'b0, (m >= 3) && (m < 11)});
            chk("serr_sample", m, {3'b0, sample}, 4'd0);
            chk("serr_done", m, {3'b0, frame_done}, 4'd0);
        end
        frame(8'hC6, 1'b1, -1, 8'hC6);
        idle(5);

        // 0xA3 with stop=0, then break (line held low)
        frame(8'hA3, 1'b0, -1, 8'hA3);
        for (int m = 0; m < 40; m++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("break_busy", m, {3'b0, busy}, 4'd0);
            chk("break_serr", m, {3'b0, start_err}, 4'd0);
        end
        idle(20);

        // Back-to-back frames
        frame(8'h0F, 1'b1, -1, 8'h0F);
        frame(8'hF0, 1'b1, -1, 8'hF0);
        idle(5);

        // rst at E+60 (step 62), outputs cleared the step after
        for (int m = 0; m < 62; m++) step(line_bit(m, 8'h55, 1'b1), 1'b0, 1'b1);
        chk("pre_rst_busy", 61, {3'b0, busy}, 4'd1);
        chk("pre_rst_idx", 61, bit_idx, 4'd2);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("post_rst_busy", 63, {3'b0, busy}, 4'd0);
        chk("post_rst_idx", 63, bit_idx, 4'd0);
        chk("post_rst_sample", 63, {3'b0, sample}, 4'd0);
        chk("post_rst_bitval", 63, {3'b0, bit_val}, 4'd0);
        idle(30);

        // en dropped at step 100 of frame 0x33
        for (int m = 0; m < 160; m++) begin
            step(line_bit(m, 8'h33, 1'b1), 1'b0, (m < 100) ? 1'b1 : 1'b0);
            chk("en_busy", m, {3'b0, busy}, {3'b0, (m >= 3) && (m <= 100)});
            chk("en_done", m, {3'b0, frame_done}, 4'd0);
            chk("en_serr", m, {3'b0, start_err}, 4'd0);
            if (m > 100) chk("en_sample", m, {3'b0, sample}, 4'd0);
            if (m == 100 || m == 159) chk("en_idx_hold", m, bit_idx, 4'd4);
        end
        idle(10);
        frame(8'h5A, 1'b1, -1, 8'h5A);
        idle(5);

        // One-cycle high glitch landing on the bit-3 evaluation cycle
`ifdef RECV_MAJORITY_EN
        frame(8'h00, 1'b1, 72, 8'h00);
`else
        frame(8'h00, 1'b1, 72, 8'h08);
`endif
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
